// File: rtl/uart_tx_serializer.sv
// Byte-stream UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// The line output comes from a flop loaded with the value for the next state, so the pad never glitches.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int SW = $clog2(2 * CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [SW-1:0] stop_q, stop_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign tx       = tx_q;
    assign bit_end  = (cnt_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    // Parity is taken from the byte as accepted, not from the shifting copy
                    shreg_d = tx_data;
                    par_d   = (^tx_data) ^ (PARITY == 2);
                    cnt_d   = '0;
                    idx_d   = '0;
                    stop_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (stop_q == STOP_LAST) begin
                    stop_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    stop_d = stop_q + SW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            S_PAR:   tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end
endmodule
